// File: rtl/div_timer_gen_if.sv
// div_timer_gen_if: CPU register-bus window for the divider/timer block.
//   Bus master (CPU side) drives:
//     sel      register window FF04-FF07 selected
//     addr     0=DIV 1=TIMA 2=TMA 3=TAC
//     wr, rd   one-cycle write strobe / read strobe
//     wdata    write data
//   Bus slave (timer) drives:
//     rdata    read data, valid while sel && rd
//     rdata_oe shared-bus tristate enable
//     irq      timer interrupt request, 1-cycle pulse
//     div_tap  selected divider bit for the frame sequencer
interface div_timer_gen_if;
    logic       sel;
    logic [1:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdata_oe;
    logic       irq;
    logic       div_tap;

    modport master (
        output sel, addr, wr, rd, wdata,
        input  rdata, rdata_oe, irq, div_tap
    );

    modport slave (
        input  sel, addr, wr, rd, wdata,
        output rdata, rdata_oe, irq, div_tap
    );
endinterface

// File: rtl/div_timer_gen.sv
// div_timer_gen: free-running divider (DIV), programmable counter (TIMA) with
// modulo reload (TMA), control register (TAC) and overflow interrupt.
//   clkin  core clock, all state updates on the rising edge
//   reset  asynchronous active-high reset
//   bus    register window (slave side), see div_timer_gen_if
// TIMA is clocked by the falling edge of the selected divider tap gated with
// TAC[2]. Overflow is followed by one OVF cycle (TIMA reads 00, a CPU write
// cancels the reload) and one RELOAD cycle (TIMA=TMA, irq high).
module div_timer_gen #(
    parameter int DIV_W   = 16,
    parameter int TAP0    = 9,
    parameter int TAP1    = 3,
    parameter int TAP2    = 5,
    parameter int TAP3    = 7,
    parameter int OUT_TAP = 12
) (
    input  logic            clkin,
    input  logic            reset,
    div_timer_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_OVF,
        ST_RELOAD
    } state_t;

    logic [DIV_W-1:0] divider_q;
    logic [7:0]       tima_q;
    logic [7:0]       tma_q;
    logic [2:0]       tac_q;
    state_t           state_q;
    logic             irq_q;
    logic             tap_q;

    logic             we_div;
    logic             we_tima;
    logic             we_tma;
    logic             we_tac;
    logic             tap_bit;
    logic             sig;
    logic             tick;
    logic [7:0]       tma_d;
    logic [7:0]       rdata_c;

    assign we_div  = bus.sel && bus.wr && (bus.addr == 2'd0);
    assign we_tima = bus.sel && bus.wr && (bus.addr == 2'd1);
    assign we_tma  = bus.sel && bus.wr && (bus.addr == 2'd2);
    assign we_tac  = bus.sel && bus.wr && (bus.addr == 2'd3);

    always_comb begin
        tap_bit = 1'b0;
        case (tac_q[1:0])
            2'd0: tap_bit = divider_q[TAP0];
            2'd1: tap_bit = divider_q[TAP1];
            2'd2: tap_bit = divider_q[TAP2];
            default: tap_bit = divider_q[TAP3];
        endcase
    end

    // Any 1->0 of the gated tap counts, including ones caused by clearing
    // DIV, disabling the timer or switching taps while the old tap was high.
    assign sig  = tac_q[2] && tap_bit;
    assign tick = tap_q && !sig;

    // A reload in the same cycle as a TMA write uses the freshly written value.
    assign tma_d = we_tma ? bus.wdata : tma_q;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            divider_q <= '0;
            tima_q    <= 8'h00;
            tma_q     <= 8'h00;
            tac_q     <= 3'b000;
            state_q   <= ST_RUN;
            irq_q     <= 1'b0;
            tap_q     <= 1'b0;
        end else begin
            divider_q <= we_div ? '0 : divider_q + DIV_W'(1);
            tap_q     <= sig;
            tma_q     <= tma_d;
            irq_q     <= 1'b0;
            if (we_tac) begin
                tac_q <= bus.wdata[2:0];
            end

            case (state_q)
                ST_RUN: begin
                    // A CPU write beats a same-cycle tick; the tick is lost.
                    if (we_tima) begin
                        tima_q <= bus.wdata;
                    end else if (tick) begin
                        if (tima_q == 8'hFF) begin
                            tima_q  <= 8'h00;
                            state_q <= ST_OVF;
                        end else begin
                            tima_q <= tima_q + 8'd1;
                        end
                    end
                end
                ST_OVF: begin
                    if (we_tima) begin
                        tima_q  <= bus.wdata;
                        state_q <= ST_RUN;
                    end else begin
                        tima_q  <= tma_d;
                        irq_q   <= 1'b1;
                        state_q <= ST_RELOAD;
                    end
                end
                ST_RELOAD: begin
                    // TIMA writes are ignored here; a TMA write also lands in TIMA.
                    if (we_tma) begin
                        tima_q <= bus.wdata;
                    end
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        rdata_c = 8'h00;
        if (bus.sel && bus.rd) begin
            case (bus.addr)
                2'd0: rdata_c = divider_q[DIV_W-1 -: 8];
                2'd1: rdata_c = tima_q;
                2'd2: rdata_c = tma_q;
                default: rdata_c = {5'b11111, tac_q};
            endcase
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.rdata_oe = bus.sel && bus.rd;
    assign bus.irq      = irq_q;
    assign bus.div_tap  = divider_q[OUT_TAP];

endmodule

// File: tb/tb_div_timer_gen.sv
module tb_div_timer_gen;

    typedef struct {
        int         cyc;
        bit         oe;
        logic [7:0] rdata;
        bit         irq;
        bit         tap;
    } exp_t;

    logic clk;
    logic reset;
    div_timer_gen_if bus_if ();

    div_timer_gen dut (
        .clkin (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: timer as plain integers. m_phase counts cycles since
    // an overflow wrapped TIMA to 00 (0 = normal counting, 1 = just wrapped,
    // 2 = reload happened and irq is visible).
    int m_div, m_tima, m_tma, m_tac, m_prev_sig, m_phase;

    function automatic int tap_of(int s);
        case (s)
            0: return 9;
            1: return 3;
            2: return 5;
            default: return 7;
        endcase
    endfunction

    function automatic int bit_of(int v, int b);
        return (v >> b) & 1;
    endfunction

    task automatic model_reset();
        m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_prev_sig = 0; m_phase = 0;
    endtask

    task automatic model_step(input bit we, input int a, input int d);
        int sig, tick, tma_new;
        sig     = bit_of(m_tac, 2) & bit_of(m_div, tap_of(m_tac & 3));
        tick    = m_prev_sig & (sig ^ 1);
        tma_new = (we && a == 2) ? d : m_tma;
        if (m_phase == 0) begin
            if (we && a == 1) m_tima = d;
            else if (tick) begin
                if (m_tima == 255) begin m_tima = 0; m_phase = 1; end
                else m_tima = m_tima + 1;
            end
        end else if (m_phase == 1) begin
            if (we && a == 1) begin m_tima = d; m_phase = 0; end
            else begin m_tima = tma_new; m_phase = 2; end
        end else begin
            if (we && a == 2) m_tima = d;
            m_phase = 0;
        end
        m_div      = (we && a == 0) ? 0 : ((m_div + 1) % 65536);
        m_prev_sig = sig;
        m_tma      = tma_new;
        if (we && a == 3) m_tac = d & 7;
    endtask

    function automatic int model_read(int a);
        case (a)
            0: return (m_div >> 8) & 255;
            1: return m_tima;
            2: return m_tma;
            default: return 8'hF8 | m_tac;
        endcase
    endfunction

    task automatic cycle(input bit rst, input bit sel, input bit wr, input bit rd,
                         input int a, input int d);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        bus_if.sel    = sel;
        bus_if.wr     = wr;
        bus_if.rd     = rd;
        bus_if.addr   = 2'(a);
        bus_if.wdata  = 8'(d);
        if (rst) model_reset();
        e.cyc   = cyc;
        e.oe    = sel && rd;
        e.rdata = (sel && rd) ? 8'(model_read(a)) : 8'h00;
        e.irq   = (m_phase == 2);
        e.tap   = bit_of(m_div, 12) != 0;
        exp_q.push_back(e);
        if (!rst) model_step(sel && wr, a, d);
        cyc++;
    endtask

    task automatic rd_reg(input int a);
        cycle(0, 1, 0, 1, a, 0);
    endtask

    task automatic wr_reg(input int a, input int d);
        cycle(0, 1, 1, 0, a, d);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_phase(input int ph, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_phase == ph) break;
            rd_reg(1);
        end
        n_tests++;
        if (m_phase != ph) begin
            n_fail++;
            $display("FAIL wait_phase cyc=%0d phase=%0d required=%0d", cyc, m_phase, ph);
        end
    endtask

    // Monitor: every cycle the DUT presents irq/div_tap/rdata_oe, plus rdata on reads.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (bus_if.rdata_oe !== e.oe) begin
                    n_fail++;
                    $display("FAIL rdata_oe cyc=%0d got=%b exp=%b", e.cyc, bus_if.rdata_oe, e.oe);
                end
                n_tests++;
                if (bus_if.irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL irq cyc=%0d got=%b exp=%b", e.cyc, bus_if.irq, e.irq);
                end
                n_tests++;
                if (bus_if.div_tap !== e.tap) begin
                    n_fail++;
                    $display("FAIL div_tap cyc=%0d got=%b exp=%b", e.cyc, bus_if.div_tap, e.tap);
                end
                if (e.oe) begin
                    n_tests++;
                    if (bus_if.rdata !== e.rdata) begin
                        n_fail++;
                        $display("FAIL rdata cyc=%0d addr=%0d got=%h exp=%h",
                                 e.cyc, bus_if.addr, bus_if.rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        int r, a, d;
        reset = 1'b1;
        bus_if.sel = 0; bus_if.wr = 0; bus_if.rd = 0; bus_if.addr = 0; bus_if.wdata = 0;
        model_reset();

        // 1: idle after reset, DIV should read 01 after 256 cycles
        do_reset();
        for (int i = 0; i < 256; i++) rd_reg(i % 4);
        rd_reg(0);

        // 2: overflow with reload and irq
        do_reset();
        wr_reg(3, 8'h05); wr_reg(2, 8'hA0); wr_reg(1, 8'hFE);
        for (int i = 0; i < 40; i++) rd_reg(1);

        // 3a: write TIMA during OVF cancels reload
        do_reset();
        wr_reg(3, 8'h05); wr_reg(2, 8'hA0); wr_reg(1, 8'hFE);
        wait_phase(1, 40);
        cycle(0, 1, 1, 1, 1, 8'h33);
        for (int i = 0; i < 6; i++) rd_reg(1);

        // 3b: write TIMA during RELOAD is ignored
        wr_reg(1, 8'hFF);
        wait_phase(2, 40);
        cycle(0, 1, 1, 1, 1, 8'h33);
        for (int i = 0; i < 4; i++) rd_reg(1);

        // 3c: write TMA during RELOAD also loads TIMA
        wr_reg(1, 8'hFF);
        wait_phase(2, 40);
        cycle(0, 1, 1, 0, 2, 8'h5C);
        for (int i = 0; i < 4; i++) rd_reg(1);

        // 4: clearing DIV while tap bit is 1 / 0
        do_reset();
        wr_reg(3, 8'h05); wr_reg(1, 8'h10);
        for (int i = 0; i < 20 && bit_of(m_div, 3) == 0; i++) rd_reg(1);
        wr_reg(0, 8'h77);
        for (int i = 0; i < 4; i++) rd_reg(1);
        for (int i = 0; i < 20 && bit_of(m_div, 3) == 1; i++) rd_reg(1);
        wr_reg(0, 8'h00);
        for (int i = 0; i < 4; i++) rd_reg(1);

        // 5: disabling while tap bit is 1
        for (int i = 0; i < 20 && bit_of(m_div, 3) == 0; i++) rd_reg(1);
        wr_reg(3, 8'h01);
        for (int i = 0; i < 4; i++) rd_reg(1);
        rd_reg(3);

        // 6: reset during OVF
        do_reset();
        wr_reg(3, 8'h05); wr_reg(2, 8'hA0); wr_reg(1, 8'hFF);
        wait_phase(1, 40);
        do_reset();
        for (int i = 0; i < 30; i++) rd_reg(i % 2);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            a = $urandom_range(0, 3);
            d = $urandom_range(0, 255);
            if (m_phase != 0 && r < 30) begin
                cycle(0, 1, 1, $urandom_range(0, 1), $urandom_range(1, 2), d);
            end else if (r < 8) begin
                cycle(0, 1, 1, 1, 1, ($urandom_range(0, 1) != 0) ? $urandom_range(240, 255) : d);
            end else if (r < 11) begin
                wr_reg(2, d);
            end else if (r < 15) begin
                wr_reg(3, d);
            end else if (r < 18) begin
                cycle(0, 1, 1, 1, 0, d);
            end else if (r < 19) begin
                cycle(1, 0, 0, 0, 0, 0);
            end else if (r < 27) begin
                cycle(0, $urandom_range(0, 1), 0, $urandom_range(0, 1), a, d);
            end else begin
                rd_reg(a);
            end
        end

        cycle(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
